riscv_multicycle_ctrl: RTL and testbench
========================================

# riscv_multicycle_ctrl

- Multi-cycle main control FSM for the RV32I core subset: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, driving datapath mux selects and write strobes.
- Produces the 2-bit `alu_op` consumed by the ALU-control decoder, which combines it with funct3/funct7b5 into the 4-bit ALU operation.
- Waits on a single-cycle-ready memory handshake.

## Interface
Parameters: none.

Ports (reset is asynchronous, active-low, on `rst_n`):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register (stable from DECODE until next FETCH)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  PC register load strobe
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register (and OldPC) load strobe
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op  out  2  00 add, 01 subtract, 10 decode by funct
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- reg_write  out  1  register file write strobe
- illegal  out  1  high while in TRAP

## Operation
Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.

Outputs and state behaviour:
- Outputs are Moore decodes of state, with two Mealy exceptions: `mem_ready` gating and `zero` gating.
- Every output not listed for a state is 0.

States, outputs and transitions:
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready. Next: DECODE if mem_ready, else FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next by op:
  - lw/sw -> MEMADR
  - R -> EXECUTER
  - I -> EXECUTEI
  - beq -> BEQ
  - jal -> JAL
  - other -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB if mem_ready, else MEMREAD.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held constant until accepted). Next: FETCH if mem_ready, else MEMWRITE.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
- TRAP: illegal=1; sticky until reset.

`imm_src` is combinational from `op` in every state:
- lw / I -> 00
- sw -> 01
- beq -> 10
- jal -> 11
- unlisted -> 00

## Timing
- Reset (rst_n low, asynchronous):
  - State = FETCH.
  - pc_write, ir_write, mem_write, reg_write, illegal forced 0 regardless of `mem_ready`.
  - Mux selects show FETCH values.
- First FETCH is the first rising edge after rst_n deasserts.
- Reset mid-instruction aborts immediately; no strobe is asserted in the reset cycle.
- Cycles per instruction with mem_ready=1 always:
  - lw 5
  - sw 4
  - R/I 4
  - beq 3
  - jal 4
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle; no strobe other than mem_write fires while stalled.
- `zero` is sampled only in BEQ. `op` is sampled in DECODE, MEMADR and for `imm_src`.

## Structure
- Shared package `riscv_pkg` holds:
  - state enum (12 states, 4-bit)
  - opcode constants
  - alu_op encodings (ADD 00, SUB 01, FUNCT 10)
  - result_src, alu_src_a and alu_src_b select constants
  - imm_src encodings
- Sub-module `imm_src_dec`: combinational op -> imm_src. The FSM (state register, next-state logic, output decode) stays in the top module.

## Test plan
- lw, mem_ready=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; reg_write=1 with result_src=01 only in cycle 5.
- sw with mem_ready low 3 cycles in MEMWRITE: mem_write=1 for 4 consecutive cycles, then FETCH; reg_write stays 0 throughout.
- R-type: EXECUTER shows alu_op=10, alu_src_b=00; ALUWB shows reg_write=1, result_src=00.
- beq, two cases:
  - zero=1 -> pc_write=1 in BEQ.
  - zero=0 -> pc_write=0.
  - Both cases: alu_op=01, return to FETCH.
- jal: JAL shows pc_write=1, alu_src_a=01, alu_src_b=10, then ALUWB with reg_write=1; imm_src=11 throughout.
- Illegal and reset:
  - op=0000000 -> TRAP with illegal=1, held for 10+ cycles.
  - rst_n pulsed low mid-cycle: illegal and all strobes drop to 0 immediately (asynchronously), and the FSM resumes at FETCH.

Source files
------------

// File: rtl/riscv_multicycle_ctrl_pkg.sv
// rtl/riscv_multicycle_ctrl_pkg.sv - shared types and encodings for the multi-cycle control FSM
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// rtl/riscv_multicycle_ctrl_if.sv - control bundle between the FSM and the datapath
interface riscv_multicycle_ctrl_if;

    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal
    );

endinterface

// File: rtl/riscv_multicycle_ctrl_imm_src_dec.sv
// rtl/riscv_multicycle_ctrl_imm_src_dec.sv - opcode to immediate-format select
module imm_src_dec
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Pure opcode decode; unknown opcodes fall back to the I-type format.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multi-cycle main control FSM for the RV32I subset
module riscv_multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    riscv_multicycle_ctrl_if.master       bus
);

    state_t     state;
    state_t     state_next;

    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;

    imm_src_dec u_imm_src_dec (
        .op      (bus.op),
        .imm_src (imm_src)
    );

    // State register; reset aborts any instruction and restarts at fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing, stalling on memory in the three memory-facing states.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode: Moore per state, except fetch strobes follow mem_ready and the branch follows zero.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = bus.mem_ready;
                pc_write_raw = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_RDATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALU_OP_SUB;
                pc_write_raw = bus.zero;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: begin
                illegal_raw = 1'b0;
            end
        endcase
    end

    // Strobes are masked by rst_n so a mem_ready-driven fetch strobe cannot leak out during reset.
    assign bus.pc_write   = pc_write_raw  & rst_n;
    assign bus.ir_write   = ir_write_raw  & rst_n;
    assign bus.mem_write  = mem_write_raw & rst_n;
    assign bus.reg_write  = reg_write_raw & rst_n;
    assign bus.illegal    = illegal_raw   & rst_n;
    assign bus.adr_src    = adr_src;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.imm_src    = imm_src;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - self-checking bench for riscv_multicycle_ctrl
module tb_riscv_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       illegal;
    } ctl_t;

    localparam int P_FETCH = 0,  P_DECODE = 1, P_MEMADR = 2,  P_MEMREAD = 3,
                   P_MEMWB = 4,  P_MEMWRITE = 5, P_EXR = 6,   P_EXI = 7,
                   P_ALUWB = 8,  P_BEQ = 9,    P_JAL = 10,    P_TRAP = 11;

    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011,
                           T_I = 7'b0010011, T_BEQ = 7'b1100011, T_JAL = 7'b1101111;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [6:0] cur_op;

    riscv_multicycle_ctrl_if bus_if ();

    riscv_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == T_SW)  return 2'b01;
        if (o == T_BEQ) return 2'b10;
        if (o == T_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Expected control word for one named step, read straight from the step table.
    function automatic ctl_t expect_ctl(input int ph, input logic [6:0] o, input logic mr, input logic z);
        ctl_t e;
        e = '0;
        e.imm_src = imm_of(o);
        case (ph)
            P_FETCH:    begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr; end
            P_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            P_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            P_MEMREAD:  begin e.adr_src = 1'b1; end
            P_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            P_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            P_EXR:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            P_EXI:      begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            P_ALUWB:    begin e.reg_write = 1'b1; end
            P_BEQ:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
            P_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            P_TRAP:     begin e.illegal = 1'b1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t observe();
        ctl_t a;
        a.pc_write   = bus_if.pc_write;
        a.adr_src    = bus_if.adr_src;
        a.mem_write  = bus_if.mem_write;
        a.ir_write   = bus_if.ir_write;
        a.result_src = bus_if.result_src;
        a.alu_src_a  = bus_if.alu_src_a;
        a.alu_src_b  = bus_if.alu_src_b;
        a.alu_op     = bus_if.alu_op;
        a.imm_src    = bus_if.imm_src;
        a.reg_write  = bus_if.reg_write;
        a.illegal    = bus_if.illegal;
        return a;
    endfunction

    task automatic check(input string tag, input ctl_t exp_v);
        ctl_t obs;
        obs = observe();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle of a named step: drive inputs away from the edge, then compare.
    task automatic cyc(input string tag, input int ph, input logic mr, input logic z);
        @(negedge clk);
        bus_if.mem_ready = mr;
        bus_if.zero      = z;
        #1;
        check(tag, expect_ctl(ph, cur_op, mr, z));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One whole instruction; stalls are mem_ready-low cycles before the completing one.
    task automatic run_instr(input logic [6:0] o, input logic z, input int sf, input int sm);
        cur_op = o;
        bus_if.op = o;
        for (int i = 0; i < sf; i++) cyc("fetch_stall", P_FETCH, 1'b0, rbit());
        cyc("fetch", P_FETCH, 1'b1, rbit());
        cyc("decode", P_DECODE, rbit(), rbit());
        case (o)
            T_LW: begin
                cyc("memadr_lw", P_MEMADR, rbit(), rbit());
                for (int i = 0; i < sm; i++) cyc("memread_stall", P_MEMREAD, 1'b0, rbit());
                cyc("memread", P_MEMREAD, 1'b1, rbit());
                cyc("memwb", P_MEMWB, rbit(), rbit());
            end
            T_SW: begin
                cyc("memadr_sw", P_MEMADR, rbit(), rbit());
                for (int i = 0; i < sm; i++) cyc("memwrite_stall", P_MEMWRITE, 1'b0, rbit());
                cyc("memwrite", P_MEMWRITE, 1'b1, rbit());
            end
            T_R: begin
                cyc("execute_r", P_EXR, rbit(), rbit());
                cyc("aluwb_r", P_ALUWB, rbit(), rbit());
            end
            T_I: begin
                cyc("execute_i", P_EXI, rbit(), rbit());
                cyc("aluwb_i", P_ALUWB, rbit(), rbit());
            end
            T_BEQ: begin
                cyc("beq", P_BEQ, rbit(), z);
            end
            T_JAL: begin
                cyc("jal", P_JAL, rbit(), rbit());
                cyc("aluwb_jal", P_ALUWB, rbit(), rbit());
            end
            default: begin
                for (int i = 0; i < 12; i++) cyc("trap", P_TRAP, rbit(), rbit());
            end
        endcase
    endtask

    // Assert rst_n mid-cycle and check strobes drop at once, hold a cycle, then release before a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #3;
        bus_if.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_async", expect_ctl(P_FETCH, cur_op, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        check("reset_hold", expect_ctl(P_FETCH, cur_op, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur_op      = 7'd0;
        rst_n       = 1'b0;
        bus_if.op        = 7'd0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b1;

        @(negedge clk);
        #1;
        check("reset_state", expect_ctl(P_FETCH, cur_op, 1'b0, 1'b0));
        cur_op = T_LW;
        bus_if.op = T_LW;
        #1;
        check("reset_imm_lw", expect_ctl(P_FETCH, cur_op, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(T_LW, 1'b0, 0, 0);
        run_instr(T_SW, 1'b0, 0, 3);
        run_instr(T_R, 1'b0, 0, 0);
        run_instr(T_I, 1'b0, 1, 0);
        run_instr(T_BEQ, 1'b1, 0, 0);
        run_instr(T_BEQ, 1'b0, 0, 0);
        run_instr(T_JAL, 1'b0, 0, 0);
        run_instr(T_LW, 1'b0, 2, 2);
        run_instr(7'b0000000, 1'b0, 0, 0);
        do_reset();

        // Abort a store while it waits on memory.
        cur_op = T_SW;
        bus_if.op = T_SW;
        cyc("abort_fetch", P_FETCH, 1'b1, 1'b0);
        cyc("abort_decode", P_DECODE, 1'b1, 1'b0);
        cyc("abort_memadr", P_MEMADR, 1'b0, 1'b0);
        cyc("abort_memwrite", P_MEMWRITE, 1'b0, 1'b0);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            logic [6:0] o;
            case ($urandom_range(0, 12))
                0, 1:    o = T_LW;
                2, 3:    o = T_SW;
                4, 5:    o = T_R;
                6, 7:    o = T_I;
                8, 9:    o = T_BEQ;
                10, 11:  o = T_JAL;
                default: o = 7'b1111111;
            endcase
            run_instr(o, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
            if (o == 7'b1111111) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
